instr_prefetch_register: RTL and testbench

Parametrised instruction register with a DEPTH-entry prefetch queue between program memory and the control unit. Memory pushes fetched words with a valid/ready handshake. The control unit pops one word per `ir_load` into the output instruction register, which presents registered opcode/address fields. A `flush` input discards all queued and held instructions on a branch/jump.

---
 rtl/instr_prefetch_register.sv | 83 ++++++++
 tb/tb_instr_prefetch_register.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_register.sv
// Instruction register fed by a DEPTH-entry circular prefetch queue.
// Memory pushes with valid/ready; the control unit pops one word per ir_load.
module instr_prefetch_register #(
  parameter int DATA_WIDTH   = 16,
  parameter int OPCODE_WIDTH = 5,
  parameter int DEPTH        = 4
) (
  input  logic                               iclk,
  input  logic                               irst_n,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_WIDTH-1:0]              insin,
  input  logic                               ir_load,
  output logic                               ir_valid,
  output logic [OPCODE_WIDTH-1:0]            opcode,
  output logic [DATA_WIDTH-OPCODE_WIDTH-1:0] address,
  output logic [$clog2(DEPTH+1)-1:0]         count,
  output logic                               full,
  output logic                               empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = DATA_WIDTH - OPCODE_WIDTH;

  // Handshake: a word transfers on a rising edge where in_valid && in_ready
  // and flush is low; in_ready depends only on the count register.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  push;
  logic                  pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign count    = count_q;

  assign push = in_valid && in_ready && !flush;
  assign pop  = ir_load && !empty && !flush;

  // Storage is not reset; only pointers and count define what is live.
  always_ff @(posedge iclk) begin
    if (push) mem[wr_ptr] <= insin;
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Flush and load-on-empty only invalidate; the fields keep their last value.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      ir_valid <= 1'b0;
      opcode   <= '0;
      address  <= '0;
    end else if (flush) begin
      ir_valid <= 1'b0;
    end else if (pop) begin
      ir_valid <= 1'b1;
      opcode   <= mem[rd_ptr][DATA_WIDTH-1 -: OPCODE_WIDTH];
      address  <= mem[rd_ptr][AW-1:0];
    end else if (ir_load) begin
      ir_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_register.sv
// Directed and random checks of instr_prefetch_register against a queue-based
// reference model of the prefetch queue and instruction register.
module tb_instr_prefetch_register;

  localparam int DW    = 16;
  localparam int OW    = 5;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int AW    = DW - OW;

  logic          iclk;
  logic          irst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] insin;
  logic          ir_load;
  logic          ir_valid;
  logic [OW-1:0] opcode;
  logic [AW-1:0] address;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DW-1:0] exp_q[$];
  logic          m_irv;
  logic [DW-1:0] m_ir;

  instr_prefetch_register #(.DATA_WIDTH(DW), .OPCODE_WIDTH(OW), .DEPTH(DEPTH)) dut (
    .iclk(iclk), .irst_n(irst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .insin(insin), .ir_load(ir_load), .ir_valid(ir_valid),
    .opcode(opcode), .address(address), .count(count), .full(full), .empty(empty)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    chk({tag, "_full"}, 32'(full), 32'(exp_q.size() == DEPTH));
    chk({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(exp_q.size() < DEPTH));
    chk({tag, "_ir_valid"}, 32'(ir_valid), 32'(m_irv));
    chk({tag, "_opcode"}, 32'(opcode), 32'(m_ir >> AW));
    chk({tag, "_address"}, 32'(address), 32'(m_ir % (1 << AW)));
  endtask

  // One clock: drive inputs, step the model from the pre-edge state, check after the edge.
  task automatic cycle(input logic v, input logic [DW-1:0] w, input logic ld,
                       input logic fl, input string tag);
    int  size_before;
    logic do_pop;
    logic do_push;
    in_valid = v;
    insin    = w;
    ir_load  = ld;
    flush    = fl;
    size_before = exp_q.size();
    @(posedge iclk);
    #1;
    if (fl) begin
      exp_q.delete();
      m_irv = 1'b0;
    end else begin
      do_pop  = ld && (size_before > 0);
      do_push = v && (size_before < DEPTH);
      if (do_pop) begin
        m_ir  = exp_q.pop_front();
        m_irv = 1'b1;
      end else if (ld) begin
        m_irv = 1'b0;
      end
      if (do_push) exp_q.push_back(w);
    end
    chk_model(tag);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_irv = 1'b0;
    m_ir  = '0;
  endtask

  initial begin
    logic [DW-1:0] fill_words [4];
    logic [DW-1:0] seq_word;
    fill_words[0] = 16'h8801;
    fill_words[1] = 16'h1002;
    fill_words[2] = 16'h2003;
    fill_words[3] = 16'h3004;

    irst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; insin = '0; ir_load = 1'b0;
    model_reset();
    repeat (2) @(posedge iclk);
    #1;
    chk_model("reset_init");
    irst_n = 1'b1;

    // Some traffic, then an asynchronous reset between edges.
    cycle(1'b1, 16'hA123, 1'b0, 1'b0, "pre_rst0");
    cycle(1'b1, 16'hB456, 1'b1, 1'b0, "pre_rst1");
    cycle(1'b1, 16'hC789, 1'b1, 1'b0, "pre_rst2");
    in_valid = 1'b1; insin = 16'hDDDD; ir_load = 1'b1;
    #2;
    irst_n = 1'b0;
    #1;
    model_reset();
    chk_model("async_rst");
    chk("async_rst_empty", 32'(empty), 32'd1);
    in_valid = 1'b0; ir_load = 1'b0;
    @(posedge iclk);
    #1;
    irst_n = 1'b1;

    // Fill and drain.
    for (int i = 0; i < 4; i++) cycle(1'b1, fill_words[i], 1'b0, 1'b0, "fill");
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 16'h4005, 1'b0, 1'b0, "fifth_rejected");
    chk("fifth_count", 32'(count), 32'd4);
    cycle(1'b0, '0, 1'b1, 1'b0, "drain0");
    chk("drain0_op", 32'(opcode), 32'h11);
    chk("drain0_addr", 32'(address), 32'h001);
    cycle(1'b0, '0, 1'b1, 1'b0, "drain1");
    chk("drain1_op", 32'(opcode), 32'h02);
    chk("drain1_addr", 32'(address), 32'h002);
    cycle(1'b0, '0, 1'b1, 1'b0, "drain2");
    chk("drain2_op", 32'(opcode), 32'h04);
    chk("drain2_addr", 32'(address), 32'h003);
    cycle(1'b0, '0, 1'b1, 1'b0, "drain3");
    chk("drain3_op", 32'(opcode), 32'h06);
    chk("drain3_addr", 32'(address), 32'h004);

    // Load on empty.
    cycle(1'b0, '0, 1'b1, 1'b0, "load_empty");
    chk("load_empty_irv", 32'(ir_valid), 32'd0);
    chk("load_empty_op", 32'(opcode), 32'h06);
    chk("load_empty_addr", 32'(address), 32'h004);

    // Simultaneous push/pop at count 2; pointers wrap past DEPTH-1.
    cycle(1'b1, 16'h0100, 1'b0, 1'b0, "sim_pre0");
    cycle(1'b1, 16'h0101, 1'b0, 1'b0, "sim_pre1");
    for (int i = 0; i < 6; i++) begin
      seq_word = 16'h0102 + 16'(i);
      cycle(1'b1, seq_word, 1'b1, 1'b0, "sim");
      chk("sim_count", 32'(count), 32'd2);
      chk("sim_word", 32'({opcode, address}), 32'(16'h0100 + 16'(i)));
    end

    // Flush priority at count 3.
    cycle(1'b1, 16'h0200, 1'b0, 1'b0, "fl_pre");
    chk("fl_pre_count", 32'(count), 32'd3);
    cycle(1'b1, 16'hBEEF, 1'b1, 1'b1, "flush");
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_irv", 32'(ir_valid), 32'd0);
    cycle(1'b1, 16'h0300, 1'b0, 1'b0, "post_fl_push");
    cycle(1'b0, '0, 1'b1, 1'b0, "post_fl_pop");
    chk("post_fl_word", 32'({opcode, address}), 32'h0300);
    cycle(1'b0, '0, 1'b1, 1'b0, "post_fl_empty");

    // Latency: push at edge N with ir_load held high.
    cycle(1'b1, 16'hF7FF, 1'b1, 1'b0, "lat_n");
    chk("lat_n_irv", 32'(ir_valid), 32'd0);
    cycle(1'b0, '0, 1'b1, 1'b0, "lat_n1");
    chk("lat_n1_irv", 32'(ir_valid), 32'd1);
    chk("lat_n1_op", 32'(opcode), 32'h1E);
    chk("lat_n1_addr", 32'(address), 32'h7FF);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 60), 16'($urandom), 1'($urandom_range(0, 99) < 50),
            1'($urandom_range(0, 99) < 4), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
